// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter.
//   XLEN_DEFAULT : default datapath width
//   REG_ADDR_W   : register address width (32 architectural registers)
//   wb_sel_e     : which source owns the register-file write port this cycle
package regfile_wb_arbiter_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned REG_ADDR_W   = 5;

  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_LSU  = 2'd1,
    WB_FIFO = 2'd2,
    WB_ALU  = 2'd3
  } wb_sel_e;

endpackage

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// wb_fifo: DEPTH-entry in-order {rd, data} queue for ALU results that lost
// write-port arbitration.
//   clk, rst              : clock, synchronous active-high reset
//   push, push_rd/data    : enqueue at tail
//   pop                   : dequeue head (caller guarantees non-empty)
//   count                 : current occupancy, 0..DEPTH
//   ord_valid/rd/data     : entries in age order, slot 0 = head (oldest)
module wb_fifo
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned XLEN  = XLEN_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [REG_ADDR_W-1:0]         push_rd,
  input  logic [XLEN-1:0]               push_data,
  input  logic                          pop,
  output logic [$clog2(DEPTH+1)-1:0]    count,
  output logic [DEPTH-1:0]              ord_valid,
  output logic [DEPTH*REG_ADDR_W-1:0]   ord_rd,
  output logic [DEPTH*XLEN-1:0]         ord_data
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [REG_ADDR_W-1:0] rd_mem   [DEPTH];
  logic [XLEN-1:0]       data_mem [DEPTH];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= ptr_inc(tail);
      if (pop)  head <= ptr_inc(head);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload needs no reset: entries are only observed through ord_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[tail]   <= push_rd;
      data_mem[tail] <= push_data;
    end
  end

  // Rotate storage into age order so consumers never deal with wrap.
  always_comb begin
    int unsigned idx;
    ord_valid = '0;
    ord_rd    = '0;
    ord_data  = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = 32'(head) + k;
      if (idx >= DEPTH) idx = idx - DEPTH;
      ord_valid[k]                        = (k < 32'(count));
      ord_rd[k*REG_ADDR_W +: REG_ADDR_W]  = rd_mem[PTR_W'(idx)];
      ord_data[k*XLEN +: XLEN]            = data_mem[PTR_W'(idx)];
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between the LSU
// (fixed priority, no backpressure) and the ALU (queued when it loses), and
// forwards queued/in-flight results onto the decode read path.
//   clk, rst                       : clock, synchronous active-high reset
//   i_alu_* / o_alu_ready          : ALU valid/ready writeback channel
//   i_lsu_*                        : LSU writeback, always accepted
//   o_wb_write_en/rd/data          : register-file write port
//   i_du_rs1/2, i_rf_data1/2       : decode read addresses and raw RF data
//   o_exec_data1/2                 : forwarded operands
//   o_pending_mask                 : one bit per rd held in the ALU queue
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned XLEN  = XLEN_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_alu_valid,
  input  logic [REG_ADDR_W-1:0] i_alu_rd,
  input  logic [XLEN-1:0]       i_alu_data,
  output logic                  o_alu_ready,
  input  logic                  i_lsu_valid,
  input  logic [REG_ADDR_W-1:0] i_lsu_rd,
  input  logic [XLEN-1:0]       i_lsu_data,
  output logic                  o_wb_write_en,
  output logic [REG_ADDR_W-1:0] o_wb_rd,
  output logic [XLEN-1:0]       o_wb_data,
  input  logic [REG_ADDR_W-1:0] i_du_rs1,
  input  logic [REG_ADDR_W-1:0] i_du_rs2,
  input  logic [XLEN-1:0]       i_rf_data1,
  input  logic [XLEN-1:0]       i_rf_data2,
  output logic [XLEN-1:0]       o_exec_data1,
  output logic [XLEN-1:0]       o_exec_data2,
  output logic [31:0]           o_pending_mask
);

  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [CNT_W-1:0]             count;
  logic [DEPTH-1:0]             ord_valid;
  logic [DEPTH*REG_ADDR_W-1:0]  ord_rd;
  logic [DEPTH*XLEN-1:0]        ord_data;
  logic                         alu_fire;
  logic                         lsu_wr;
  logic                         alu_wr;
  logic                         fifo_nonempty;
  logic                         push;
  logic                         pop;
  wb_sel_e                      wb_sel;

  wb_fifo #(.DEPTH(DEPTH), .XLEN(XLEN)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_rd   (i_alu_rd),
    .push_data (i_alu_data),
    .pop       (pop),
    .count     (count),
    .ord_valid (ord_valid),
    .ord_rd    (ord_rd),
    .ord_data  (ord_data)
  );

  assign o_alu_ready   = !rst && (count < CNT_W'(DEPTH));
  assign alu_fire      = i_alu_valid && o_alu_ready;
  assign lsu_wr        = !rst && i_lsu_valid && (i_lsu_rd != '0);
  assign alu_wr        = alu_fire && (i_alu_rd != '0);
  assign fifo_nonempty = !rst && (count != '0);

  always_comb begin
    wb_sel = WB_NONE;
    if (lsu_wr)             wb_sel = WB_LSU;
    else if (fifo_nonempty) wb_sel = WB_FIFO;
    else if (alu_wr)        wb_sel = WB_ALU;
  end

  // Any accepted non-zero ALU result that did not go straight to the port
  // is queued; this keeps it behind every older queued entry.
  assign push = alu_wr && (wb_sel != WB_ALU);
  assign pop  = (wb_sel == WB_FIFO);

  always_comb begin
    o_wb_write_en = 1'b0;
    o_wb_rd       = '0;
    o_wb_data     = '0;
    unique case (wb_sel)
      WB_LSU: begin
        o_wb_write_en = 1'b1;
        o_wb_rd       = i_lsu_rd;
        o_wb_data     = i_lsu_data;
      end
      WB_FIFO: begin
        o_wb_write_en = 1'b1;
        o_wb_rd       = ord_rd[REG_ADDR_W-1:0];
        o_wb_data     = ord_data[XLEN-1:0];
      end
      WB_ALU: begin
        o_wb_write_en = 1'b1;
        o_wb_rd       = i_alu_rd;
        o_wb_data     = i_alu_data;
      end
      default: ;
    endcase
  end

  always_comb begin
    o_pending_mask = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (ord_valid[k] && !rst)
        o_pending_mask[ord_rd[k*REG_ADDR_W +: REG_ADDR_W]] = 1'b1;
    end
  end

  // Queue scan runs oldest to youngest so the last hit is the youngest;
  // the write port is only consulted when no queued entry matches.
  always_comb begin
    logic hit1, hit2;
    hit1 = 1'b0;
    hit2 = 1'b0;
    o_exec_data1 = i_rf_data1;
    o_exec_data2 = i_rf_data2;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (ord_valid[k] && !rst && ord_rd[k*REG_ADDR_W +: REG_ADDR_W] == i_du_rs1) begin
        o_exec_data1 = ord_data[k*XLEN +: XLEN];
        hit1         = 1'b1;
      end
      if (ord_valid[k] && !rst && ord_rd[k*REG_ADDR_W +: REG_ADDR_W] == i_du_rs2) begin
        o_exec_data2 = ord_data[k*XLEN +: XLEN];
        hit2         = 1'b1;
      end
    end
    if (!hit1 && o_wb_write_en && o_wb_rd == i_du_rs1) o_exec_data1 = o_wb_data;
    if (!hit2 && o_wb_write_en && o_wb_rd == i_du_rs2) o_exec_data2 = o_wb_data;
    if (i_du_rs1 == '0) o_exec_data1 = '0;
    if (i_du_rs2 == '0) o_exec_data2 = '0;
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_alu_valid;
  logic [4:0]  i_alu_rd;
  logic [31:0] i_alu_data;
  logic        o_alu_ready;
  logic        i_lsu_valid;
  logic [4:0]  i_lsu_rd;
  logic [31:0] i_lsu_data;
  logic        o_wb_write_en;
  logic [4:0]  o_wb_rd;
  logic [31:0] o_wb_data;
  logic [4:0]  i_du_rs1, i_du_rs2;
  logic [31:0] i_rf_data1, i_rf_data2;
  logic [31:0] o_exec_data1, o_exec_data2;
  logic [31:0] o_pending_mask;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DEPTH(2), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .i_alu_valid(i_alu_valid), .i_alu_rd(i_alu_rd), .i_alu_data(i_alu_data),
    .o_alu_ready(o_alu_ready),
    .i_lsu_valid(i_lsu_valid), .i_lsu_rd(i_lsu_rd), .i_lsu_data(i_lsu_data),
    .o_wb_write_en(o_wb_write_en), .o_wb_rd(o_wb_rd), .o_wb_data(o_wb_data),
    .i_du_rs1(i_du_rs1), .i_du_rs2(i_du_rs2),
    .i_rf_data1(i_rf_data1), .i_rf_data2(i_rf_data2),
    .o_exec_data1(o_exec_data1), .o_exec_data2(o_exec_data2),
    .o_pending_mask(o_pending_mask)
  );

  // Inputs change on the falling edge; checks run 1 time unit later,
  // well before the next rising edge samples them.
  task automatic cycle(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ldat);
    @(negedge clk);
    i_alu_valid = av; i_alu_rd = ard; i_alu_data = adat;
    i_lsu_valid = lv; i_lsu_rd = lrd; i_lsu_data = ldat;
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_du_rs1 = 5'd0; i_du_rs2 = 5'd0; i_rf_data1 = '0; i_rf_data2 = '0;
    cycle(1'b1, 5'd5, 32'h1, 1'b1, 5'd6, 32'h2);
    checks++; if (o_wb_write_en !== 1'b0) begin errors++; $display("FAIL rst_wb_en: got %b want 0", o_wb_write_en); end
    checks++; if (o_alu_ready !== 1'b0) begin errors++; $display("FAIL rst_alu_ready: got %b want 0", o_alu_ready); end
    idle();
    checks++; if (o_pending_mask !== 32'h0) begin errors++; $display("FAIL rst_mask: got %h want 0", o_pending_mask); end
    @(negedge clk); rst = 1'b0;
    idle();
    checks++; if (o_alu_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready: got %b want 1", o_alu_ready); end
    checks++; if (o_wb_write_en !== 1'b0) begin errors++; $display("FAIL post_rst_wb_en: got %b want 0", o_wb_write_en); end
    checks++; if (o_pending_mask !== 32'h0) begin errors++; $display("FAIL post_rst_mask: got %h want 0", o_pending_mask); end
  endtask

  task automatic test_alu_direct();
    cycle(1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'h0);
    checks++; if ({o_wb_write_en, o_wb_rd, o_wb_data} !== {1'b1, 5'd5, 32'h11})
      begin errors++; $display("FAIL alu_direct: got en=%b rd=%0d data=%h want en=1 rd=5 data=11", o_wb_write_en, o_wb_rd, o_wb_data); end
    idle();
    checks++; if (o_pending_mask !== 32'h0 || o_wb_write_en !== 1'b0)
      begin errors++; $display("FAIL alu_direct_noqueue: got mask=%h en=%b want mask=0 en=0", o_pending_mask, o_wb_write_en); end
  endtask

  task automatic test_lsu_alu_collision();
    cycle(1'b1, 5'd4, 32'hBB, 1'b1, 5'd3, 32'hAA);
    checks++; if ({o_wb_write_en, o_wb_rd, o_wb_data, o_alu_ready} !== {1'b1, 5'd3, 32'hAA, 1'b1})
      begin errors++; $display("FAIL coll_c0: got en=%b rd=%0d data=%h rdy=%b want en=1 rd=3 data=aa rdy=1", o_wb_write_en, o_wb_rd, o_wb_data, o_alu_ready); end
    idle();
    checks++; if (o_pending_mask !== 32'h0000_0010)
      begin errors++; $display("FAIL coll_mask4: got %h want 00000010", o_pending_mask); end
    checks++; if ({o_wb_write_en, o_wb_rd, o_wb_data} !== {1'b1, 5'd4, 32'hBB})
      begin errors++; $display("FAIL coll_c1: got en=%b rd=%0d data=%h want en=1 rd=4 data=bb", o_wb_write_en, o_wb_rd, o_wb_data); end
    idle();
    checks++; if (o_pending_mask !== 32'h0 || o_wb_write_en !== 1'b0)
      begin errors++; $display("FAIL coll_drain: got mask=%h en=%b want mask=0 en=0", o_pending_mask, o_wb_write_en); end
  endtask

  task automatic test_backpressure();
    cycle(1'b1, 5'd6, 32'h66, 1'b1, 5'd10, 32'h100);
    checks++; if (o_alu_ready !== 1'b1 || o_wb_rd !== 5'd10)
      begin errors++; $display("FAIL bp_c0: got rdy=%b rd=%0d want rdy=1 rd=10", o_alu_ready, o_wb_rd); end
    cycle(1'b1, 5'd7, 32'h77, 1'b1, 5'd11, 32'h101);
    checks++; if (o_alu_ready !== 1'b1 || o_pending_mask !== 32'h0000_0040)
      begin errors++; $display("FAIL bp_c1: got rdy=%b mask=%h want rdy=1 mask=00000040", o_alu_ready, o_pending_mask); end
    cycle(1'b1, 5'd8, 32'h88, 1'b1, 5'd12, 32'h102);
    checks++; if (o_alu_ready !== 1'b0 || o_pending_mask !== 32'h0000_00C0 || o_wb_rd !== 5'd12)
      begin errors++; $display("FAIL bp_c2_full: got rdy=%b mask=%h rd=%0d want rdy=0 mask=000000c0 rd=12", o_alu_ready, o_pending_mask, o_wb_rd); end
    cycle(1'b1, 5'd8, 32'h88, 1'b0, 5'd0, 32'h0);
    checks++; if (o_alu_ready !== 1'b0 || {o_wb_write_en, o_wb_rd, o_wb_data} !== {1'b1, 5'd6, 32'h66})
      begin errors++; $display("FAIL bp_pop6: got rdy=%b en=%b rd=%0d data=%h want rdy=0 en=1 rd=6 data=66", o_alu_ready, o_wb_write_en, o_wb_rd, o_wb_data); end
    cycle(1'b1, 5'd8, 32'h88, 1'b0, 5'd0, 32'h0);
    checks++; if (o_alu_ready !== 1'b1 || {o_wb_write_en, o_wb_rd, o_wb_data} !== {1'b1, 5'd7, 32'h77})
      begin errors++; $display("FAIL bp_pop7: got rdy=%b en=%b rd=%0d data=%h want rdy=1 en=1 rd=7 data=77", o_alu_ready, o_wb_write_en, o_wb_rd, o_wb_data); end
    idle();
    checks++; if ({o_wb_write_en, o_wb_rd, o_wb_data} !== {1'b1, 5'd8, 32'h88} || o_pending_mask !== 32'h0000_0100)
      begin errors++; $display("FAIL bp_pop8: got en=%b rd=%0d data=%h mask=%h want en=1 rd=8 data=88 mask=00000100", o_wb_write_en, o_wb_rd, o_wb_data, o_pending_mask); end
    idle();
    checks++; if (o_wb_write_en !== 1'b0 || o_pending_mask !== 32'h0)
      begin errors++; $display("FAIL bp_empty: got en=%b mask=%h want en=0 mask=0", o_wb_write_en, o_pending_mask); end
  endtask

  task automatic test_forwarding();
    cycle(1'b1, 5'd9, 32'h1, 1'b1, 5'd1, 32'h10);
    cycle(1'b1, 5'd9, 32'h2, 1'b1, 5'd2, 32'h20);
    i_rf_data1 = 32'hFF; i_rf_data2 = 32'h55;
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h33);
    i_du_rs1 = 5'd9; i_du_rs2 = 5'd3; #1;
    checks++; if (o_exec_data1 !== 32'h2) begin errors++; $display("FAIL fwd_youngest: got %h want 2", o_exec_data1); end
    checks++; if (o_exec_data2 !== 32'h33) begin errors++; $display("FAIL fwd_wbport: got %h want 33", o_exec_data2); end
    i_du_rs1 = 5'd0; #1;
    checks++; if (o_exec_data1 !== 32'h0) begin errors++; $display("FAIL fwd_rs0: got %h want 0", o_exec_data1); end
    i_du_rs1 = 5'd5; #1;
    checks++; if (o_exec_data1 !== 32'hFF) begin errors++; $display("FAIL fwd_rf: got %h want ff", o_exec_data1); end
    // LSU targets the same rd as the queue head: LSU writes, head stays.
    i_du_rs1 = 5'd9;
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99);
    checks++; if ({o_wb_write_en, o_wb_rd, o_wb_data} !== {1'b1, 5'd9, 32'h99} || o_exec_data1 !== 32'h2)
      begin errors++; $display("FAIL lsu_same_rd: got en=%b rd=%0d data=%h fwd=%h want en=1 rd=9 data=99 fwd=2", o_wb_write_en, o_wb_rd, o_wb_data, o_exec_data1); end
    idle();
    checks++; if (o_wb_data !== 32'h1 || o_pending_mask !== 32'h0000_0200)
      begin errors++; $display("FAIL fwd_drain_old: got data=%h mask=%h want data=1 mask=00000200", o_wb_data, o_pending_mask); end
    idle();
    checks++; if (o_wb_data !== 32'h2 || o_wb_rd !== 5'd9)
      begin errors++; $display("FAIL fwd_drain_young: got rd=%0d data=%h want rd=9 data=2", o_wb_rd, o_wb_data); end
    i_du_rs1 = 5'd0; i_du_rs2 = 5'd0;
    idle();
  endtask

  task automatic test_rd_zero();
    cycle(1'b1, 5'd0, 32'h5, 1'b0, 5'd0, 32'h0);
    checks++; if (o_wb_write_en !== 1'b0 || o_alu_ready !== 1'b1)
      begin errors++; $display("FAIL alu_rd0: got en=%b rdy=%b want en=0 rdy=1", o_wb_write_en, o_alu_ready); end
    idle();
    checks++; if (o_pending_mask !== 32'h0 || o_wb_write_en !== 1'b0)
      begin errors++; $display("FAIL alu_rd0_noqueue: got mask=%h en=%b want mask=0 en=0", o_pending_mask, o_wb_write_en); end
    cycle(1'b1, 5'd4, 32'h44, 1'b1, 5'd0, 32'h7);
    checks++; if ({o_wb_write_en, o_wb_rd, o_wb_data} !== {1'b1, 5'd4, 32'h44})
      begin errors++; $display("FAIL lsu_rd0: got en=%b rd=%0d data=%h want en=1 rd=4 data=44", o_wb_write_en, o_wb_rd, o_wb_data); end
    idle();
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 5'd20, 32'h20, 1'b1, 5'd1, 32'h0);
    cycle(1'b1, 5'd21, 32'h21, 1'b1, 5'd2, 32'h0);
    @(negedge clk); rst = 1'b1;
    i_alu_valid = 1'b0; i_lsu_valid = 1'b0; #1;
    checks++; if (o_wb_write_en !== 1'b0 || o_pending_mask !== 32'h0)
      begin errors++; $display("FAIL rst_mid: got en=%b mask=%h want en=0 mask=0", o_wb_write_en, o_pending_mask); end
    @(negedge clk); rst = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (o_wb_write_en !== 1'b0 || o_pending_mask !== 32'h0 || o_alu_ready !== 1'b1)
        begin errors++; $display("FAIL rst_mid_after%0d: got en=%b mask=%h rdy=%b want en=0 mask=0 rdy=1", i, o_wb_write_en, o_pending_mask, o_alu_ready); end
      idle();
    end
    checks++; if (dut.u_fifo.count !== 2'd0)
      begin errors++; $display("FAIL rst_mid_count: got %0d want 0", dut.u_fifo.count); end
  endtask

  initial begin
    test_reset();
    test_alu_direct();
    test_lsu_alu_collision();
    test_backpressure();
    test_forwarding();
    test_rd_zero();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the register file's single synchronous write port between two writeback sources: the ALU path and the load/store unit (LSU). LSU results have fixed priority. ALU results that lose arbitration are parked in a small in-order FIFO. The block also forwards pending and in-flight write data onto the decode-side read path, and exports a pending-rd mask so the hazard logic can stall on WAW/RAW conflicts. It sits between the execute/memory stages and the register file write port.

## Interface
- `DEPTH`, 2: ALU holding-FIFO entries, ≥1.
- `XLEN`, `` `XLEN ``: data width, from `macros.hv`.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `i_alu_valid`  in  1  ALU result offered.
- `i_alu_rd`  in  5  ALU destination register.
- `i_alu_data`  in  XLEN  ALU result.
- `o_alu_ready`  out  1  ALU result accepted when high together with valid.
- `i_lsu_valid`  in  1  LSU result offered; always accepted.
- `i_lsu_rd`  in  5  LSU destination register.
- `i_lsu_data`  in  XLEN  LSU result.
- `o_wb_write_en`  out  1  write strobe to the register file.
- `o_wb_rd`  out  5  write address.
- `o_wb_data`  out  XLEN  write data.
- `i_du_rs1`, `i_du_rs2`  in  5 each  decode read addresses, also sent to the register file.
- `i_rf_data1`, `i_rf_data2`  in  XLEN each  raw register-file read data.
- `o_exec_data1`, `o_exec_data2`  out  XLEN each  forwarded operands.
- `o_pending_mask`  out  32  bit r is set when any FIFO entry targets r.

## Operation
- Handshakes:
  - ALU: a transfer occurs when `i_alu_valid & o_alu_ready`.
  - `o_alu_ready = !rst && (count < DEPTH)`. It does not depend on `i_alu_valid`.
  - LSU has no backpressure.
- An rd of 0 is dropped at entry from either source: it is never enqueued and never written. `o_wb_write_en` is never high with `o_wb_rd == 0`.
- Write-port selection, each cycle, in priority order:
  1. LSU valid with rd≠0: LSU wins.
  2. FIFO non-empty: the FIFO head is written and popped.
  3. ALU transfer with rd≠0: written directly, bypassing the FIFO.
  4. Otherwise `o_wb_write_en = 0`.
- Enqueue rule: an accepted ALU result is enqueued unless it was selected at priority 3. Push and pop in the same cycle are legal, and count is unchanged.
- Ordering:
  - FIFO order equals ALU acceptance order.
  - The FIFO is never bypassed while non-empty.
  - WAW avoidance between LSU and queued ALU entries is the responsibility of the hazard logic, using `o_pending_mask`.
- Forwarding, per read port, first match wins:
  1. rs=0 → 0.
  2. Youngest FIFO entry with rd==rs.
  3. The current write port (`o_wb_write_en && o_wb_rd==rs`).
  4. `i_rf_data`.
- Pointer and width rules:
  - Head and tail pointers wrap modulo DEPTH.
  - count is `$clog2(DEPTH+1)` bits and stays in the range 0..DEPTH.

## Timing
- Reset:
  - While `rst` is high: count=0, pointers=0, `o_wb_write_en=0`, `o_alu_ready=0`, `o_pending_mask=0`.
  - FIFO data contents are don't-care.
  - Reset asserted mid-operation discards all queued entries. Nothing is written in that cycle or afterwards from the discarded entries.
- Latency:
  - `o_wb_*`, `o_alu_ready`, `o_exec_data*` and `o_pending_mask` are combinational from inputs and registered state.
  - A direct write lands in the register file at the next edge.
  - A queued entry is written after every older entry. While LSU traffic is present, this takes at least 1 cycle per older entry plus 1 cycle per LSU write.
- `o_pending_mask` reflects the FIFO state before this cycle's push or pop.
- Boundary conditions:
  - Full: `o_alu_ready=0` even if a pop occurs in the same cycle.
  - Empty with LSU valid: the ALU result is enqueued.
  - LSU and FIFO head writing the same rd in the same cycle: LSU is written and the head stays queued.

## Structure
- `XLEN` comes from `macros.hv`.
- Add `` `REG_ADDR_W `` (5) to `macros.hv`.
- Sub-module `wb_fifo`: a DEPTH-entry {rd, data} FIFO with push/pop, count, and per-entry valid/rd visibility for forwarding and mask generation.
- The top level holds the arbitration mux and the forwarding logic.

## Test plan
- Reset, then rst low for 1 cycle: `o_alu_ready=1`, `o_wb_write_en=0`, `o_pending_mask=0`.
- ALU only, rd=5, data=0x11: same-cycle `o_wb_write_en=1`, rd=5, data=0x11; FIFO count stays 0.
- LSU rd=3/0xAA and ALU rd=4/0xBB together, then idle: cycle 0 writes x3=0xAA and `o_pending_mask[4]=1`; cycle 1 writes x4=0xBB; mask clears.
- LSU valid for 3 cycles with ALU rd=6,7,8:
  - Cycles 0 and 1 accept rd=6 and rd=7.
  - Cycle 2 has `o_alu_ready=0`.
  - After the LSU stops, x6 then x7 are written in order, then rd=8 is accepted.
- Forwarding: FIFO holds rd=9/0x1 (older) and rd=9/0x2 (younger), `i_rf_data1=0xFF`, rs1=9 → `o_exec_data1=0x2`. rs1=0 → 0.
- rd=0 from the ALU: `o_wb_write_en=0`, no enqueue.
- Reset asserted with 2 queued entries: no further writes, count=0.
